stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch. It conditions the raw start/stop and lap push-buttons, then runs the run/pause/lap/clear state machine. It drives the enable, clear and lap-capture strobes of the time-count datapath and the freeze select of the 7-segment display path. It sits between the board buttons and the counter/display blocks and is their only source of control.

---
 rtl/sw_pkg.sv | 21 ++
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/btn_event.sv | 78 +++++++
 rtl/stopwatch_ctrl.sv | 101 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pkg
// Brief    : Shared state encodings and clock-derived timing constants.
// Revision : 1.0
// ============================================================================
package sw_pkg;

    localparam int CLK_HZ           = 27_000_000;
    localparam int DB_CYCLES_DEF    = CLK_HZ / 100;
    localparam int LONG_CYCLES_DEF  = CLK_HZ;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_t;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_if
// Brief    : Button inputs and counter/display control outputs.
// Revision : 1.0
// ============================================================================
interface stopwatch_ctrl_if;

    logic       btn_ss_n;
    logic       btn_lap_n;
    logic       count_en;
    logic       count_clr;
    logic       lap_capture;
    logic       disp_freeze;
    logic [1:0] state;

    modport master (
        output btn_ss_n, btn_lap_n,
        input  count_en, count_clr, lap_capture, disp_freeze, state
    );

    modport slave (
        input  btn_ss_n, btn_lap_n,
        output count_en, count_clr, lap_capture, disp_freeze, state
    );

endinterface
`default_nettype wire

// File: rtl/btn_event.sv
`default_nettype none
// ============================================================================
// Module   : btn_event
// Brief    : Button synchronizer, debouncer and short/long press detector.
// Revision : 1.0
// ============================================================================
module btn_event #(
    parameter int DB_CYCLES   = 4,
    parameter int LONG_CYCLES = 20
) (
    input  wire logic sys_clk,
    input  wire logic sys_rst_n,
    input  wire logic btn_n,
    output logic      short_evt,
    output logic      long_evt,
    output logic      level
);

    localparam int c_db_w   = $clog2(DB_CYCLES + 1);
    localparam int c_hold_w = $clog2(LONG_CYCLES + 1);
    localparam logic [c_db_w-1:0]   c_db_last  = c_db_w'(DB_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_pre = c_hold_w'(LONG_CYCLES - 1);

    logic [1:0]          r_sync;
    logic [c_db_w-1:0]   r_db_cnt;
    logic [c_hold_w-1:0] r_hold;
    logic                r_level;
    logic                r_level_d;
    logic                r_armed;
    logic                r_short;
    logic                r_long;
    logic                w_sync_press;

    assign w_sync_press = ~r_sync[1];

    // Synchronizer resets to "pressed" so a button held through reset keeps
    // r_armed low until it has been seen released; only then do events fire.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync    <= 2'b00;
            r_db_cnt  <= '0;
            r_hold    <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_armed   <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], btn_n};
            r_level_d <= r_level;
            if (w_sync_press != r_level) begin
                if (r_db_cnt == c_db_last) begin
                    r_level  <= w_sync_press;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
            if (r_level) begin
                if (r_hold != c_hold_max) r_hold <= r_hold + 1'b1;
            end else begin
                r_hold <= '0;
            end
            if (!r_level && !w_sync_press) r_armed <= 1'b1;
            r_long  <= r_armed && r_level && (r_hold == c_hold_pre);
            r_short <= r_armed && r_level_d && !r_level && (r_hold < c_hold_max);
        end
    end

    assign short_evt = r_short;
    assign long_evt  = r_long;
    assign level     = r_level;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Run/pause/lap/clear sequencer driving the stopwatch datapath.
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl
    import sw_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst_n,
    stopwatch_ctrl_if.slave  bus
);

    logic      w_ss_short, w_ss_long, w_ss_level;
    logic      w_lap_short, w_lap_long, w_lap_level;
    logic      w_unused_levels;
    sw_state_t r_state, w_nxt;
    logic      w_clr, w_cap;
    logic      r_count_en, r_count_clr, r_lap_capture, r_disp_freeze;

    btn_event #(.DB_CYCLES(DB_CYCLES), .LONG_CYCLES(LONG_CYCLES)) u_ss (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_n     (bus.btn_ss_n),
        .short_evt (w_ss_short),
        .long_evt  (w_ss_long),
        .level     (w_ss_level)
    );

    btn_event #(.DB_CYCLES(DB_CYCLES), .LONG_CYCLES(LONG_CYCLES)) u_lap (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_n     (bus.btn_lap_n),
        .short_evt (w_lap_short),
        .long_evt  (w_lap_long),
        .level     (w_lap_level)
    );

    assign w_unused_levels = w_ss_level ^ w_lap_level ^ w_lap_long;

    // Any start/stop event takes priority and suppresses a same-cycle lap event.
    always_comb begin
        w_nxt = r_state;
        w_clr = 1'b0;
        w_cap = 1'b0;
        if (w_ss_long) begin
            if (r_state != ST_IDLE) begin
                w_nxt = ST_IDLE;
                w_clr = 1'b1;
            end
        end else if (w_ss_short) begin
            case (r_state)
                ST_IDLE:  w_nxt = ST_RUN;
                ST_RUN:   w_nxt = ST_PAUSE;
                ST_LAP:   w_nxt = ST_PAUSE;
                ST_PAUSE: w_nxt = ST_RUN;
                default:  w_nxt = ST_IDLE;
            endcase
        end else if (w_lap_short) begin
            case (r_state)
                ST_RUN, ST_LAP: begin
                    w_nxt = ST_LAP;
                    w_cap = 1'b1;
                end
                ST_PAUSE: begin
                    w_nxt = ST_IDLE;
                    w_clr = 1'b1;
                end
                default: w_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_count_en    <= 1'b0;
            r_count_clr   <= 1'b0;
            r_lap_capture <= 1'b0;
            r_disp_freeze <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_count_en    <= (w_nxt == ST_RUN) || (w_nxt == ST_LAP);
            r_count_clr   <= w_clr;
            r_lap_capture <= w_cap;
            r_disp_freeze <= (w_nxt == ST_LAP);
        end
    end

    assign bus.state       = r_state;
    assign bus.count_en    = r_count_en;
    assign bus.count_clr   = r_count_clr;
    assign bus.lap_capture = r_lap_capture;
    assign bus.disp_freeze = r_disp_freeze;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Vector table, corner sequences and random model check.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int DB   = 4;
    localparam int LONG = 20;

    typedef struct {
        bit is_lap;
        int len;
        int exp_state;
        int exp_en;
        int exp_frz;
        int exp_clr;
        int exp_cap;
    } vec_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int clr_seen = 0, cap_seen = 0, viol = 0;
    int m_state = 0;

    // Pulse monitor, sampled mid-high-phase away from both edges.
    always @(posedge sys_clk) begin
        #2;
        if (sys_rst_n) begin
            if (bus.count_clr)   clr_seen++;
            if (bus.lap_capture) cap_seen++;
            if (bus.count_clr && bus.lap_capture) viol++;
            if (bus.count_clr && bus.count_en)    viol++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit ss, input bit lap, input int len);
        @(negedge sys_clk);
        if (ss)  bus.btn_ss_n  = 1'b0;
        if (lap) bus.btn_lap_n = 1'b0;
        repeat (len) @(negedge sys_clk);
        bus.btn_ss_n  = 1'b1;
        bus.btn_lap_n = 1'b1;
        repeat (40) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic check_outs(input string name, input int st, input int clr_d,
                              input int cap_d, input int v_d);
        check({name, "_state"}, int'(bus.state), st);
        check({name, "_en"},    int'(bus.count_en), (st == 1 || st == 2) ? 1 : 0);
        check({name, "_frz"},   int'(bus.disp_freeze), (st == 2) ? 1 : 0);
        check({name, "_clr"},   clr_d, 0);
        check({name, "_cap"},   cap_d, 0);
        check({name, "_viol"},  v_d, 0);
    endtask

    // Reference: event table derived from the state diagram.
    task automatic model_event(input bit is_lap, input bit is_long,
                               output int e_clr, output int e_cap);
        int ss_next[4];
        int lap_next[4];
        ss_next  = '{1, 3, 3, 1};
        lap_next = '{0, 2, 2, 0};
        e_clr = 0;
        e_cap = 0;
        if (!is_lap && is_long) begin
            if (m_state != 0) begin
                m_state = 0;
                e_clr = 1;
            end
        end else if (!is_lap) begin
            m_state = ss_next[m_state];
        end else if (!is_long) begin
            if (m_state == 1 || m_state == 2) e_cap = 1;
            if (m_state == 3) e_clr = 1;
            m_state = lap_next[m_state];
        end
    endtask

    initial begin
        vec_t vecs[13];
        int c0, k0, v0, e_clr, e_cap, len;
        bit is_lap;

        vecs[0]  = '{0, 10, 1, 1, 0, 0, 0};
        vecs[1]  = '{1, 10, 2, 1, 1, 0, 1};
        vecs[2]  = '{1, 10, 2, 1, 1, 0, 1};
        vecs[3]  = '{0, 10, 3, 0, 0, 0, 0};
        vecs[4]  = '{1, 10, 0, 0, 0, 1, 0};
        vecs[5]  = '{1, 10, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 30, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 10, 1, 1, 0, 0, 0};
        vecs[8]  = '{0, 30, 0, 0, 0, 1, 0};
        vecs[9]  = '{0, 10, 1, 1, 0, 0, 0};
        vecs[10] = '{1, 30, 1, 1, 0, 0, 0};
        vecs[11] = '{0, 10, 3, 0, 0, 0, 0};
        vecs[12] = '{0, 10, 1, 1, 0, 0, 0};

        bus.btn_ss_n  = 1'b1;
        bus.btn_lap_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_state", int'(bus.state), 0);
        check("rst_en",    int'(bus.count_en), 0);
        check("rst_clr",   int'(bus.count_clr), 0);
        check("rst_cap",   int'(bus.lap_capture), 0);
        check("rst_frz",   int'(bus.disp_freeze), 0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        foreach (vecs[i]) begin
            c0 = clr_seen; k0 = cap_seen; v0 = viol;
            press(!vecs[i].is_lap, vecs[i].is_lap, vecs[i].len);
            check($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].exp_state);
            check($sformatf("vec%0d_en", i),    int'(bus.count_en), vecs[i].exp_en);
            check($sformatf("vec%0d_frz", i),   int'(bus.disp_freeze), vecs[i].exp_frz);
            check($sformatf("vec%0d_clr", i),   clr_seen - c0, vecs[i].exp_clr);
            check($sformatf("vec%0d_cap", i),   cap_seen - k0, vecs[i].exp_cap);
            check($sformatf("vec%0d_viol", i),  viol - v0, 0);
        end

        // Bounce on start/stop from RUN: never stable for DB cycles.
        c0 = clr_seen; k0 = cap_seen; v0 = viol;
        for (int t = 0; t < 10; t++) begin
            @(negedge sys_clk); bus.btn_ss_n = ~bus.btn_ss_n;
            @(negedge sys_clk);
        end
        bus.btn_ss_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        check_outs("bounce", 1, clr_seen - c0, cap_seen - k0, viol - v0);

        // Long start/stop hold from RUN: clear fires while still held.
        c0 = clr_seen;
        @(negedge sys_clk);
        bus.btn_ss_n = 1'b0;
        repeat (29) @(negedge sys_clk);
        check("long_held_state", int'(bus.state), 0);
        check("long_held_clr", clr_seen - c0, 1);
        check("long_held_en", int'(bus.count_en), 0);
        @(negedge sys_clk);
        bus.btn_ss_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        check("long_rel_state", int'(bus.state), 0);
        check("long_rel_clr", clr_seen - c0, 1);

        // Simultaneous events in RUN: start/stop wins.
        press(1'b1, 1'b0, 10);
        check("sim_pre_state", int'(bus.state), 1);
        k0 = cap_seen;
        press(1'b1, 1'b1, 10);
        check("sim_state", int'(bus.state), 3);
        check("sim_cap", cap_seen - k0, 0);
        check("sim_frz", int'(bus.disp_freeze), 0);

        // Asynchronous reset from LAP, with start/stop held across it.
        press(1'b1, 1'b0, 10);
        press(1'b0, 1'b1, 10);
        check("lap_pre_state", int'(bus.state), 2);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("arst_state", int'(bus.state), 0);
        check("arst_en",    int'(bus.count_en), 0);
        check("arst_frz",   int'(bus.disp_freeze), 0);
        check("arst_clr",   int'(bus.count_clr), 0);
        check("arst_cap",   int'(bus.lap_capture), 0);
        bus.btn_ss_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        c0 = clr_seen; k0 = cap_seen; v0 = viol;
        repeat (10) @(negedge sys_clk);
        bus.btn_ss_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        check_outs("midpress", 0, clr_seen - c0, cap_seen - k0, viol - v0);
        press(1'b1, 1'b0, 10);
        check("repress_state", int'(bus.state), 1);

        // Random clean presses against the reference model.
        do_reset();
        m_state = 0;
        for (int n = 0; n < 30; n++) begin
            is_lap = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(26, 40))
                                              : int'($urandom_range(6, 14));
            repeat ($urandom_range(0, 5)) @(negedge sys_clk);
            c0 = clr_seen; k0 = cap_seen; v0 = viol;
            model_event(is_lap, len >= LONG, e_clr, e_cap);
            press(!is_lap, is_lap, len);
            check($sformatf("rnd%0d_state", n), int'(bus.state), m_state);
            check($sformatf("rnd%0d_en", n),  int'(bus.count_en),
                  (m_state == 1 || m_state == 2) ? 1 : 0);
            check($sformatf("rnd%0d_frz", n), int'(bus.disp_freeze), (m_state == 2) ? 1 : 0);
            check($sformatf("rnd%0d_clr", n), clr_seen - c0, e_clr);
            check($sformatf("rnd%0d_cap", n), cap_seen - k0, e_cap);
            check($sformatf("rnd%0d_viol", n), viol - v0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
